// File: rtl/ps2_seq_pkg.sv
// Shared types and constants for the PS/2 command sequencer: FSM states,
// protocol reply bytes and error codes.
package ps2_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_RESP,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_TX_TIMEOUT   = 3'd1;
    localparam logic [2:0] ERR_RETRIES      = 3'd2;
    localparam logic [2:0] ERR_UNEXPECTED   = 3'd3;
    localparam logic [2:0] ERR_RESP_TIMEOUT = 3'd4;

endpackage

// File: rtl/ps2_seq_timer.sv
// Device-reply watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module ps2_seq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear || expired) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: flops update with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ps2_command_sequencer.sv
// Sends one PS/2 host command, handles ACK/RESEND/response bytes and timeouts,
// and forwards unsolicited device bytes as a scan-code stream while idle.
module ps2_command_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    input  logic [1:0] cmd_resp_len,
    output logic       cmd_ready,
    output logic       send_command,
    output logic [7:0] the_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    output logic       wait_for_incoming_data,
    output logic       start_receiving_data,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       stream_valid,
    output logic [7:0] stream_data,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_last,
    output logic       done,
    output logic       err_valid,
    output logic [2:0] err_code
);

    localparam int unsigned RW = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    state_e        state_q, state_d;
    logic [7:0]    the_command_q, the_command_d;
    logic [1:0]    remaining_q, remaining_d;
    logic [RW-1:0] retries_q, retries_d;
    logic          send_command_q, send_command_d;
    logic          wait_q, wait_d;
    logic          stream_valid_q, stream_valid_d;
    logic [7:0]    stream_data_q, stream_data_d;
    logic          resp_valid_q, resp_valid_d;
    logic [7:0]    resp_data_q, resp_data_d;
    logic          resp_last_q, resp_last_d;
    logic          done_q, done_d;
    logic          err_valid_q, err_valid_d;
    logic [2:0]    err_code_q, err_code_d;

    logic in_wait;
    logic timer_expired;

    assign in_wait   = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_RESP);
    assign cmd_ready = (state_q == ST_IDLE) && !received_data_en;

    // Restarts whenever we are not waiting, so entry into a wait state starts at zero.
    ps2_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (!in_wait || received_data_en),
        .enable (in_wait),
        .expired(timer_expired)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_d        = state_q;
        the_command_d  = the_command_q;
        remaining_d    = remaining_q;
        retries_d      = retries_q;
        stream_valid_d = 1'b0;
        stream_data_d  = stream_data_q;
        resp_valid_d   = 1'b0;
        resp_data_d    = resp_data_q;
        resp_last_d    = 1'b0;
        err_code_d     = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (received_data_en) begin
                    stream_valid_d = 1'b1;
                    stream_data_d  = received_data;
                end else if (cmd_valid) begin
                    the_command_d = cmd_byte;
                    remaining_d   = cmd_resp_len;
                    retries_d     = '0;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (error_communication_timed_out) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TX_TIMEOUT;
                end else if (command_was_sent) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (received_data_en) begin
                    if (received_data == PS2_ACK) begin
                        state_d = (remaining_q == 2'd0) ? ST_DONE : ST_WAIT_RESP;
                    end else if (received_data == PS2_RESEND) begin
                        if (retries_q < RETRY_LIMIT) begin
                            retries_d = retries_q + 1'b1;
                            state_d   = ST_SEND;
                        end else begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_RETRIES;
                        end
                    end else begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_UNEXPECTED;
                    end
                end else if (timer_expired) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_RESP_TIMEOUT;
                end
            end
            ST_WAIT_RESP: begin
                if (received_data_en) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = received_data;
                    resp_last_d  = (remaining_q == 2'd1);
                    remaining_d  = remaining_q - 2'd1;
                    if (remaining_q == 2'd1) begin
                        state_d = ST_DONE;
                    end
                end else if (timer_expired) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_RESP_TIMEOUT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Level outputs follow the state being entered so they are registered with it.
        send_command_d = (state_d == ST_SEND);
        wait_d         = (state_d == ST_IDLE) || (state_d == ST_WAIT_ACK) ||
                         (state_d == ST_WAIT_RESP);
        done_d         = (state_d == ST_DONE);
        err_valid_d    = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            the_command_q  <= 8'h00;
            remaining_q    <= 2'd0;
            retries_q      <= '0;
            send_command_q <= 1'b0;
            wait_q         <= 1'b1;
            stream_valid_q <= 1'b0;
            stream_data_q  <= 8'h00;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 8'h00;
            resp_last_q    <= 1'b0;
            done_q         <= 1'b0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            the_command_q  <= the_command_d;
            remaining_q    <= remaining_d;
            retries_q      <= retries_d;
            send_command_q <= send_command_d;
            wait_q         <= wait_d;
            stream_valid_q <= stream_valid_d;
            stream_data_q  <= stream_data_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_last_q    <= resp_last_d;
            done_q         <= done_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
        end
    end

    assign send_command           = send_command_q;
    assign the_command            = the_command_q;
    assign wait_for_incoming_data = wait_q;
    assign start_receiving_data   = 1'b0;
    assign stream_valid           = stream_valid_q;
    assign stream_data            = stream_data_q;
    assign resp_valid             = resp_valid_q;
    assign resp_data              = resp_data_q;
    assign resp_last              = resp_last_q;
    assign done                   = done_q;
    assign err_valid              = err_valid_q;
    assign err_code               = err_code_q;

endmodule
